// File: rtl/fetch_if.sv
// Fetch-side bus bundle: imem address/data, redirect request and the
// valid/ready instruction stream towards decode.
interface fetch_if #(
   parameter int ADDR_W = 6
);
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_q;
   logic              redirect_valid;
   logic [63:0]       redirect_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       instr;
   logic [63:0]       instr_pc;

   modport master (
      output imem_addr,
      input  imem_q,
      input  redirect_valid,
      input  redirect_pc,
      output instr_valid,
      input  instr_ready,
      output instr,
      output instr_pc
   );

   modport slave (
      input  imem_addr,
      output imem_q,
      output redirect_valid,
      output redirect_pc,
      input  instr_valid,
      output instr_ready,
      input  instr,
      input  instr_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC ownership, imem addressing and a small
// prefetch FIFO of {pc, instr} pairs handed to decode; redirects flush it.
module fetch_unit #(
   parameter int          ADDR_W     = 6,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [63:0] RESET_PC   = 64'd0
) (
   input  logic     clk,
   input  logic     reset,
   fetch_if.master  bus
);
   localparam int              PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [63:0]      fetch_pc_r;
   logic [63:0]      pc_mem_r  [FIFO_DEPTH];
   logic [31:0]      ins_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             valid_s;
   logic             pop_s;
   logic             push_s;

   assign bus.imem_addr = fetch_pc_r[ADDR_W+1:2];

   // Handshake decode; a full FIFO may still push when the head leaves this cycle.
   always_comb begin
      valid_s = (count_r != {(PTR_W+1){1'b0}});
      pop_s   = valid_s && bus.instr_ready;
      push_s  = !bus.redirect_valid && ((count_r < FULL_CNT) || pop_s);
   end

   // Head presentation, driven purely from registered FIFO state.
   always_comb begin
      bus.instr_valid = valid_s;
      if (valid_s) begin
         bus.instr    = ins_mem_r[rd_ptr_r];
         bus.instr_pc = pc_mem_r[rd_ptr_r];
      end else begin
         bus.instr    = 32'd0;
         bus.instr_pc = 64'd0;
      end
   end

   // PC, pointers and occupancy; redirect overrides both push and pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_r <= RESET_PC;
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= {(PTR_W+1){1'b0}};
      end else if (bus.redirect_valid) begin
         fetch_pc_r <= {bus.redirect_pc[63:2], 2'b00};
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= {(PTR_W+1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r   <= wr_ptr_r + PTR_ONE;
            fetch_pc_r <= fetch_pc_r + 64'd4;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; a written slot stays frozen until popped or flushed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            pc_mem_r[i]  <= 64'd0;
            ins_mem_r[i] <= 32'd0;
         end
      end else if (push_s) begin
         pc_mem_r[wr_ptr_r]  <= fetch_pc_r;
         ins_mem_r[wr_ptr_r] <= bus.imem_q;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational ROM model and a
// sequential-PC scoreboard for the randomised phase.
module tb_fetch_unit;
   logic clk;
   logic reset;
   int   errors;
   int   checks;
   int   accepted;
   logic [63:0] exp_pc;
   logic        rdy;
   logic        rdr;
   logic [63:0] rpc;

   fetch_if #(.ADDR_W(6)) ifc ();

   fetch_unit #(.ADDR_W(6), .FIFO_DEPTH(4), .RESET_PC(64'd0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.master)
   );

   function automatic logic [31:0] rom(input logic [5:0] a);
      case (a)
         6'd0:    rom = 32'h8b1f03e0;
         6'd5:    rom = 32'h91002001;
         6'd11:   rom = 32'hb50000a2;
         6'd19:   rom = 32'hf8000001;
         default: rom = 32'hd503201f;
      endcase
   endfunction

   assign ifc.imem_q = rom(ifc.imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic head(input string tag, input logic [63:0] pc, input logic [31:0] w);
      check({tag, " valid"}, {63'd0, ifc.instr_valid}, 64'd1);
      check({tag, " pc"}, ifc.instr_pc, pc);
      check({tag, " instr"}, {32'd0, ifc.instr}, {32'd0, w});
   endtask

   task automatic empty(input string tag);
      check({tag, " valid"}, {63'd0, ifc.instr_valid}, 64'd0);
      check({tag, " instr"}, {32'd0, ifc.instr}, 64'd0);
      check({tag, " pc"}, ifc.instr_pc, 64'd0);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      accepted = 0;
      reset = 1'b1;
      ifc.instr_ready = 1'b0;
      ifc.redirect_valid = 1'b0;
      ifc.redirect_pc = 64'd0;
      tick();
      tick();
      empty("reset");
      check("reset imem_addr", {58'd0, ifc.imem_addr}, 64'd0);

      // 1: streaming with ready high
      reset = 1'b0;
      ifc.instr_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         head("stream", 64'(4 * k), rom(6'(k)));
      end

      // 2: stall with ready low, then drain without gaps
      reset = 1'b1;
      tick();
      reset = 1'b0;
      ifc.instr_ready = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      head("stall", 64'd0, 32'h8b1f03e0);
      check("stall imem_addr", {58'd0, ifc.imem_addr}, 64'd4);
      ifc.instr_ready = 1'b1;
      for (int k = 1; k < 5; k++) begin
         tick();
         head("drain", 64'(4 * k), rom(6'(k)));
      end

      // 3: redirect while full
      ifc.instr_ready = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      head("full", 64'h10, rom(6'd4));
      check("full imem_addr", {58'd0, ifc.imem_addr}, 64'd8);
      ifc.redirect_valid = 1'b1;
      ifc.redirect_pc = 64'h2F;
      tick();
      ifc.redirect_valid = 1'b0;
      empty("redir flush");
      check("redir imem_addr", {58'd0, ifc.imem_addr}, 64'd11);
      tick();
      head("redir target", 64'h2C, 32'hb50000a2);

      // 4: imem_addr wraps while instr_pc keeps counting
      ifc.instr_ready = 1'b1;
      ifc.redirect_valid = 1'b1;
      ifc.redirect_pc = 64'hFC;
      tick();
      ifc.redirect_valid = 1'b0;
      empty("wrap flush");
      check("wrap addr63", {58'd0, ifc.imem_addr}, 64'd63);
      tick();
      head("wrap fc", 64'hFC, 32'hd503201f);
      check("wrap addr0", {58'd0, ifc.imem_addr}, 64'd0);
      tick();
      head("wrap 100", 64'h100, 32'h8b1f03e0);

      // back-to-back redirects: last one wins
      ifc.redirect_valid = 1'b1;
      ifc.redirect_pc = 64'h14;
      tick();
      ifc.redirect_pc = 64'h4E;
      tick();
      ifc.redirect_valid = 1'b0;
      empty("b2b flush");
      check("b2b imem_addr", {58'd0, ifc.imem_addr}, 64'd19);
      tick();
      head("b2b target", 64'h4C, 32'hf8000001);

      // 5: asynchronous reset with three entries held
      reset = 1'b1;
      tick();
      reset = 1'b0;
      ifc.instr_ready = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      head("held", 64'd0, 32'h8b1f03e0);
      check("held imem_addr", {58'd0, ifc.imem_addr}, 64'd3);
      #2;
      reset = 1'b1;
      #1;
      empty("async rst");
      check("async rst imem_addr", {58'd0, ifc.imem_addr}, 64'd0);
      tick();
      reset = 1'b0;
      ifc.instr_ready = 1'b1;
      tick();
      head("restart0", 64'd0, 32'h8b1f03e0);
      tick();
      head("restart4", 64'd4, 32'hd503201f);

      // 6: random ready/redirect against an in-order PC scoreboard
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_pc = 64'd0;
      for (int c = 0; c < 1000; c++) begin
         rdy = ($urandom_range(0, 9) < 7);
         rdr = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 2))
            0:       rpc = 64'($urandom_range(0, 255));
            1:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            default: rpc = {$urandom, $urandom};
         endcase
         ifc.instr_ready = rdy;
         ifc.redirect_valid = rdr;
         ifc.redirect_pc = rpc;
         if (!ifc.instr_valid) begin
            check("rnd idle instr", {32'd0, ifc.instr}, 64'd0);
         end else if (rdy && !rdr) begin
            check("rnd pc", ifc.instr_pc, exp_pc);
            check("rnd instr", {32'd0, ifc.instr}, {32'd0, rom(exp_pc[7:2])});
            exp_pc = exp_pc + 64'd4;
            accepted++;
         end
         if (rdr) exp_pc = {rpc[63:2], 2'b00};
         tick();
      end
      ifc.redirect_valid = 1'b0;
      check("rnd progress", {63'd0, accepted > 200}, 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
